// File: rtl/m_scroll_ctrl_pkg.sv
// Shared types and constants for the 7-seg message scroller.
// States, blank glyph, ROM geometry and address helper.
package m_scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam int ROM_DEPTH = 16;
  localparam int ADR_W = $clog2(ROM_DEPTH);

  localparam logic [ADR_W-1:0] ADR_LAST =
    ADR_W'(ROM_DEPTH - 1);

  // Address after a; last entry wraps to 0.
  function automatic logic [ADR_W-1:0] adr_next(
    input logic [ADR_W-1:0] a
  );
    return (a == ADR_LAST) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/m_scroll_ctrl_if.sv
// Character ROM bus between the scroller and the glyph ROM.
// Address and message select out, active-low glyph back.
interface m_scroll_ctrl_if;
  import m_scroll_ctrl_pkg::*;

  logic [ADR_W-1:0] rom_adr;
  logic             rom_mode;
  logic [7:0]       rom_dat;

  modport master (
    output rom_adr,
    output rom_mode,
    input  rom_dat
  );

  modport slave (
    input  rom_adr,
    input  rom_mode,
    output rom_dat
  );

endinterface

// File: rtl/m_scroll_ctrl_tick_gen.sv
// Scroll-rate prescaler: one tick every DIV enabled cycles.
// Counter is cleared whenever en is low.
module m_tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..DIV-1 while enabled, hold at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/m_scroll_ctrl.sv
// Scrolls the 16-glyph ROM message across DIGITS 7-seg digits.
// Optional wrap pause: define SCROLL_PAUSE_EN.
module m_scroll_ctrl
  import m_scroll_ctrl_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV         = 25000000,
  parameter int PAUSE_STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode_in,
  m_scroll_ctrl_if.master       rom,
  output logic [8*DIGITS-1:0]   seg_buf,
  output logic                  step,
  output logic                  frame_done
);

  localparam int PW =
    (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(PAUSE_STEPS - 1);

  state_t           state;
  state_t           nxt;
  logic             tick;
  logic             run;
  logic             fetch;
  logic             pausing;
  logic             at_last;
  logic             pause_done;
  logic [ADR_W-1:0] adr_q;
  logic             mode_q;
  logic [PW-1:0]    pcnt;

  assign rom.rom_adr  = adr_q;
  assign rom.rom_mode = mode_q;

  assign at_last    = (adr_q == ADR_LAST);
  assign pause_done = tick && (pcnt == P_LAST);

  // Prescaler only runs while waiting or pausing,
  // so a fetch cycle stretches the step period by one.
  m_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic; fetch always lasts one cycle.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (en) nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!en)       nxt = S_IDLE;
        else if (tick) nxt = S_FETCH;
      end
      S_FETCH: begin
`ifdef SCROLL_PAUSE_EN
        if (!en)          nxt = S_IDLE;
        else if (at_last) nxt = S_PAUSE;
        else              nxt = S_WAIT;
`else
        if (!en) nxt = S_IDLE;
        else     nxt = S_WAIT;
`endif
      end
      S_PAUSE: begin
        if (!en)             nxt = S_IDLE;
        else if (pause_done) nxt = S_WAIT;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    fetch   = 1'b0;
    pausing = 1'b0;
    run     = 1'b0;
    unique case (1'b1)
      (state == S_FETCH): fetch = 1'b1;
      (state == S_PAUSE): begin
        pausing = 1'b1;
        run     = en;
      end
      (state == S_WAIT):  run = en;
      default: ;
    endcase
  end

  // Pause length counter, cleared outside S_PAUSE.
  always_ff @(posedge clk) begin
    if (rst || !pausing) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= pause_done ? '0 : pcnt + 1'b1;
    end
  end

  // Shift buffer, address, mode latch and pulses.
  // Mode only changes at the 15->0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q      <= '0;
      mode_q     <= mode_in;
      seg_buf    <= {DIGITS{GLYPH_BLANK}};
      step       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      step       <= fetch;
      frame_done <= fetch && at_last;
      if (fetch) begin
        seg_buf <= {seg_buf[8*DIGITS-9:0], rom.rom_dat};
        adr_q   <= adr_next(adr_q);
        if (at_last) mode_q <= mode_in;
      end
    end
  end

endmodule

// File: tb/tb_m_scroll_ctrl.sv
// Self-checking bench for m_scroll_ctrl (DIGITS=4, DIV=4).
// Scoreboard tracks message position from observed steps.
module tb_m_scroll_ctrl;

  localparam int DIV   = 4;
  localparam int PSTEP = 4;
  localparam int GAP   = DIV + 1;
`ifdef SCROLL_PAUSE_EN
  localparam int WGAP  = GAP + PSTEP * DIV;
`else
  localparam int WGAP  = GAP;
`endif

  localparam logic [7:0] ROM0 [16] = '{
    8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hBF, 8'hC0, 8'hF9,
    8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] ROM1 [16] = '{
    8'hC2, 8'hC0, 8'hC0, 8'hA1, 8'hFF, 8'h83, 8'h91, 8'h86,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode_in;
  logic [31:0] seg_buf;
  logic        step;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [31:0] m_buf;
  int          m_adr;
  logic        m_mode;

  function automatic logic [7:0] rom_glyph(
    input logic m, input logic [3:0] a
  );
    return m ? ROM1[a] : ROM0[a];
  endfunction

  m_scroll_ctrl_if bus ();

  assign bus.rom_dat = rom_glyph(bus.rom_mode, bus.rom_adr);

  m_scroll_ctrl #(
    .DIGITS      (4),
    .DIV         (DIV),
    .PAUSE_STEPS (PSTEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode_in    (mode_in),
    .rom        (bus.master),
    .seg_buf    (seg_buf),
    .step       (step),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc_n);
    $fatal(1, "watchdog");
  end

  task automatic nclk;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b0;
    mode_in = 1'b1;
    repeat (2) nclk;
    checks++;
    if (bus.rom_mode !== 1'b1)
      $display("FAIL rst_mode1 got %b exp 1", bus.rom_mode);
    if (bus.rom_mode !== 1'b1) errors++;
    mode_in = 1'b0;
    nclk;
    checks++;
    if (bus.rom_mode !== 1'b0) begin
      errors++;
      $display("FAIL rst_mode0 got %b exp 0", bus.rom_mode);
    end
    checks++;
    if (seg_buf !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rst_buf got %h exp ffffffff", seg_buf);
    end
    checks++;
    if (bus.rom_adr !== 4'd0) begin
      errors++;
      $display("FAIL rst_adr got %0d exp 0", bus.rom_adr);
    end
    checks++;
    if (step !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse got %b%b exp 00",
               step, frame_done);
    end
    m_buf  = 32'hFFFF_FFFF;
    m_adr  = 0;
    m_mode = 1'b0;
    rst = 1'b0;
    repeat (8) nclk;
    checks++;
    if (step !== 1'b0 || seg_buf !== m_buf) begin
      errors++;
      $display("FAIL idle_hold got %b/%h exp 0/%h",
               step, seg_buf, m_buf);
    end
  endtask

  task automatic test_hello;
    int got;
    int last;
    got  = 0;
    last = -1;
    en = 1'b1;
    for (int i = 0; i < 200 && got < 4; i++) begin
      nclk;
      if (step === 1'b1) begin
        m_buf = {m_buf[23:0], rom_glyph(m_mode, m_adr[3:0])};
        m_adr = (m_adr + 1) % 16;
        checks++;
        if (seg_buf !== m_buf) begin
          errors++;
          $display("FAIL hello_buf got %h exp %h",
                   seg_buf, m_buf);
        end
        if (last >= 0) begin
          checks++;
          if (cyc_n - last != GAP) begin
            errors++;
            $display("FAIL hello_gap got %0d exp %0d",
                     cyc_n - last, GAP);
          end
        end
        last = cyc_n;
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL hello_steps got %0d exp 4", got);
    end
    checks++;
    if (seg_buf !== 32'h89_86_C7_C7) begin
      errors++;
      $display("FAIL hello_text got %h exp 8986c7c7", seg_buf);
    end
    checks++;
    if (bus.rom_adr !== 4'd4) begin
      errors++;
      $display("FAIL hello_adr got %0d exp 4", bus.rom_adr);
    end
    nclk;
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL step_width got %b exp 0", step);
    end
  endtask

  task automatic test_frame;
    int got;
    int fds;
    int last;
    int old;
    bit gap_ok;
    got  = 0;
    fds  = 0;
    last = -1;
    for (int i = 0; i < 1000 && got < 12; i++) begin
      nclk;
      if (step === 1'b1) begin
        old = m_adr;
        m_buf = {m_buf[23:0], rom_glyph(m_mode, m_adr[3:0])};
        m_adr = (m_adr + 1) % 16;
        if (old == 15) m_mode = mode_in;
        got++;
        if (frame_done === 1'b1) fds++;
        checks++;
        if (frame_done !== (old == 15)) begin
          errors++;
          $display("FAIL frame_fd got %b exp %b at adr %0d",
                   frame_done, old == 15, old);
        end
        checks++;
        if (seg_buf !== m_buf) begin
          errors++;
          $display("FAIL frame_buf got %h exp %h",
                   seg_buf, m_buf);
        end
        if (got == 1) mode_in = 1'b1;
        last = cyc_n;
      end else if (frame_done === 1'b1) begin
        fds++;
      end
      checks++;
      if (bus.rom_mode !== m_mode) begin
        errors++;
        $display("FAIL frame_mode got %b exp %b",
                 bus.rom_mode, m_mode);
      end
    end
    checks++;
    if (got != 12 || fds != 1) begin
      errors++;
      $display("FAIL frame_count got %0d/%0d exp 12/1",
               got, fds);
    end
    checks++;
    if (bus.rom_adr !== 4'd0 || bus.rom_mode !== 1'b1) begin
      errors++;
      $display("FAIL frame_wrap got %0d/%b exp 0/1",
               bus.rom_adr, bus.rom_mode);
    end
    gap_ok = 1'b0;
    for (int i = 0; i < 200 && !gap_ok; i++) begin
      nclk;
      if (step === 1'b1) begin
        gap_ok = 1'b1;
        m_buf = {m_buf[23:0], rom_glyph(m_mode, m_adr[3:0])};
        m_adr = (m_adr + 1) % 16;
        checks++;
        if (cyc_n - last != WGAP) begin
          errors++;
          $display("FAIL wrap_gap got %0d exp %0d",
                   cyc_n - last, WGAP);
        end
        checks++;
        if (seg_buf[7:0] !== 8'hC2) begin
          errors++;
          $display("FAIL mode1_glyph got %h exp c2",
                   seg_buf[7:0]);
        end
      end
    end
    checks++;
    if (!gap_ok) begin
      errors++;
      $display("FAIL wrap_timeout got none exp step");
    end
  endtask

  task automatic test_en_fetch;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      nclk;
      if (step === 1'b1) begin
        seen = 1'b1;
        m_buf = {m_buf[23:0], rom_glyph(m_mode, m_adr[3:0])};
        m_adr = (m_adr + 1) % 16;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL enf_timeout got none exp step");
    end
    repeat (GAP - 1) nclk;
    en = 1'b0;
    nclk;
    m_buf = {m_buf[23:0], rom_glyph(m_mode, m_adr[3:0])};
    m_adr = (m_adr + 1) % 16;
    checks++;
    if (step !== 1'b1 || seg_buf !== m_buf) begin
      errors++;
      $display("FAIL enf_shift got %b/%h exp 1/%h",
               step, seg_buf, m_buf);
    end
    for (int i = 0; i < 20; i++) begin
      nclk;
      checks++;
      if (step !== 1'b0 || seg_buf !== m_buf ||
          bus.rom_adr !== m_adr[3:0]) begin
        errors++;
        $display("FAIL enf_frozen got %b/%h/%0d exp 0/%h/%0d",
                 step, seg_buf, bus.rom_adr, m_buf, m_adr);
      end
    end
  endtask

  task automatic test_reset_mid;
    int got;
    got = 0;
    en = 1'b1;
    for (int i = 0; i < 200 && got < 3; i++) begin
      nclk;
      if (step === 1'b1) got++;
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL rmid_steps got %0d exp 3", got);
    end
    repeat (2) nclk;
    rst = 1'b1;
    mode_in = 1'b0;
    nclk;
    checks++;
    if (seg_buf !== 32'hFFFF_FFFF || bus.rom_adr !== 4'd0) begin
      errors++;
      $display("FAIL rmid_clear got %h/%0d exp ffffffff/0",
               seg_buf, bus.rom_adr);
    end
    checks++;
    if (step !== 1'b0 || bus.rom_mode !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ctl got %b/%b exp 0/0",
               step, bus.rom_mode);
    end
    m_buf  = 32'hFFFF_FFFF;
    m_adr  = 0;
    m_mode = 1'b0;
    nclk;
    rst = 1'b0;
  endtask

  task automatic test_random;
    int en_lo;
    int en_hi;
    int since;
    int last;
    bit stable;
    bit prev_wrap;
    int old;
    en_lo = 0;
    en_hi = 0;
    since = 0;
    last = -1;
    stable = 1'b0;
    prev_wrap = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nclk;
      if (en) begin
        en_lo = 0;
        en_hi++;
      end else begin
        en_lo++;
        en_hi = 0;
        stable = 1'b0;
      end
      since++;
      if (step === 1'b1) begin
        old = m_adr;
        m_buf = {m_buf[23:0], rom_glyph(m_mode, m_adr[3:0])};
        m_adr = (m_adr + 1) % 16;
        if (old == 15) m_mode = mode_in;
        checks++;
        if (seg_buf !== m_buf || frame_done !== (old == 15)) begin
          errors++;
          $display("FAIL rnd_step got %h/%b exp %h/%b",
                   seg_buf, frame_done, m_buf, old == 15);
        end
        checks++;
        if (en_lo >= 2) begin
          errors++;
          $display("FAIL rnd_frozen got step exp none");
        end
        if (stable && last >= 0) begin
          checks++;
          if (cyc_n - last != (prev_wrap ? WGAP : GAP)) begin
            errors++;
            $display("FAIL rnd_gap got %0d exp %0d",
                     cyc_n - last, prev_wrap ? WGAP : GAP);
          end
        end
        last = cyc_n;
        stable = 1'b1;
        prev_wrap = (old == 15);
        since = 0;
      end else begin
        checks++;
        if (seg_buf !== m_buf || frame_done !== 1'b0 ||
            bus.rom_adr !== m_adr[3:0]) begin
          errors++;
          $display("FAIL rnd_hold got %h/%b/%0d exp %h/0/%0d",
                   seg_buf, frame_done, bus.rom_adr,
                   m_buf, m_adr);
        end
      end
      checks++;
      if (bus.rom_mode !== m_mode) begin
        errors++;
        $display("FAIL rnd_mode got %b exp %b",
                 bus.rom_mode, m_mode);
      end
      if (en_hi > WGAP + 2 && since > WGAP + 2) begin
        errors++;
        $display("FAIL rnd_stall got %0d idle exp <=%0d",
                 since, WGAP + 2);
        since = 0;
      end
      if ($urandom_range(15) == 0) en = ~en;
      if ($urandom_range(19) == 0) mode_in = ~mode_in;
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    mode_in = 1'b0;
    test_reset();
    test_hello();
    test_frame();
    test_en_fetch();
    test_reset_mid();
    en = 1'b1;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
